// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lenet_pkg
// Purpose  : Shared types and constants for the LeNet layer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package lenet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_EN   = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_t;

    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC    = 4;

    localparam int c_n_layers = 5;
    localparam int c_rst_cyc  = 2;

endpackage
`default_nettype wire

// File: rtl/lenet_wdt_cnt.sv
`default_nettype none
// ============================================================================
// Module   : lenet_wdt_cnt
// Purpose  : Per-layer watchdog counter; flags a layer stuck in its enable phase.
// Revision : 1.0 - initial release
// ============================================================================
module lenet_wdt_cnt #(
    parameter int          WDT_W     = 16,
    parameter int unsigned WDT_LIMIT = 16'hFFFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WDT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires during the WDT_LIMIT-th enabled cycle.
    assign expired = en && !clr && (r_cnt == WDT_W'(WDT_LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/lenet_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : lenet_layer_seq
// Purpose  : Runs the LeNet layer engines once per frame, strictly in order.
//            Optional watchdog enabled by macro LAYER_SEQ_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lenet_layer_seq
    import lenet_pkg::*;
#(
    parameter int          N_LAYERS  = c_n_layers,
    parameter int          RST_CYC   = c_rst_cyc,
    parameter int          WDT_W     = 16,
    parameter int unsigned WDT_LIMIT = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [N_LAYERS-1:0] layer_rst,
    output logic [N_LAYERS-1:0] layer_en,
    input  logic [N_LAYERS-1:0] layer_fin,
    output logic                busy,
    output logic                done,
    output logic [2:0]          cur_layer,
    output logic [15:0]         frame_cnt,
    output logic                wdt_err
);

    localparam int                  c_rcw  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [N_LAYERS-1:0] c_one  = {{(N_LAYERS-1){1'b0}}, 1'b1};
    localparam logic [2:0]          c_last = 3'(N_LAYERS - 1);

    seq_state_t       r_state;
    logic [c_rcw-1:0] r_rst_cnt;
    logic             w_wdt_exp;

`ifdef LAYER_SEQ_WDT_EN
    lenet_wdt_cnt #(
        .WDT_W     (WDT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (r_state != ST_EN),
        .en      (r_state == ST_EN),
        .expired (w_wdt_exp)
    );
`else
    // Watchdog not built: the expression is constant false.
    assign w_wdt_exp = (WDT_W == 0) && (WDT_LIMIT == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rst_cnt <= '0;
            layer_rst <= '0;
            layer_en  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_layer <= '0;
            frame_cnt <= '0;
            wdt_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    layer_rst <= '0;
                    layer_en  <= '0;
                    if (start) begin
                        r_state   <= ST_RST;
                        r_rst_cnt <= '0;
                        cur_layer <= '0;
                        layer_rst <= c_one;
                        busy      <= 1'b1;
                        wdt_err   <= 1'b0;
                    end
                end
                ST_RST: begin
                    // Finish flag is stale here; only the cycle count matters.
                    if (r_rst_cnt == c_rcw'(RST_CYC - 1)) begin
                        layer_rst <= '0;
                        layer_en  <= c_one << cur_layer;
                        r_state   <= ST_EN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_EN: begin
                    if (layer_fin[cur_layer]) begin
                        layer_en <= '0;
                        if (cur_layer == c_last) begin
                            r_state <= ST_FIN;
                        end else begin
                            cur_layer <= cur_layer + 3'd1;
                            layer_rst <= c_one << (cur_layer + 3'd1);
                            r_rst_cnt <= '0;
                            r_state   <= ST_RST;
                        end
                    end else if (w_wdt_exp) begin
                        layer_en  <= '0;
                        layer_rst <= c_one << cur_layer;
                        wdt_err   <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_FIN: begin
                    done      <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Abort overrides whatever the state decided, including FIN.
            if (abort && (r_state != ST_IDLE)) begin
                r_state   <= ST_IDLE;
                layer_en  <= '0;
                layer_rst <= '1;
                busy      <= 1'b0;
                done      <= 1'b0;
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lenet_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_lenet_layer_seq
// Purpose  : Self-checking bench for lenet_layer_seq with model layer engines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lenet_layer_seq;

    localparam int N  = 5;
    localparam int RC = 2;
    localparam int WL = 100;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] layer_rst, layer_en, layer_fin;
    logic         busy, done, wdt_err;
    logic [2:0]   cur_layer;
    logic [15:0]  frame_cnt;

    always #5 clk = ~clk;

    lenet_layer_seq #(
        .N_LAYERS  (N),
        .RST_CYC   (RC),
        .WDT_W     (16),
        .WDT_LIMIT (WL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .layer_rst (layer_rst),
        .layer_en  (layer_en),
        .layer_fin (layer_fin),
        .busy      (busy),
        .done      (done),
        .cur_layer (cur_layer),
        .frame_cnt (frame_cnt),
        .wdt_err   (wdt_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model engines: sticky fin rises lat[i] cycles after en rises, cleared by layer_rst.
    int           lat [N];
    int           ecnt[N];
    logic [N-1:0] hang  = '0;
    logic [N-1:0] fin_m = '0;
    logic [N-1:0] fin_x = '0;
    assign layer_fin = fin_m | fin_x;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (layer_rst[i]) begin
                fin_m[i] <= 1'b0;
                ecnt[i]  <= 0;
            end else if (layer_en[i] && !fin_m[i]) begin
                ecnt[i] <= ecnt[i] + 1;
                if (!hang[i] && (ecnt[i] + 1 >= lat[i])) fin_m[i] <= 1'b1;
            end
        end
    end

    // Monitor: cycle stamps of enable rises and done pulses.
    int           cyc = 0;
    int           rise[N];
    int           done_cyc = 0;
    int           done_n = 0;
    logic         done_busy = 1'b0;
    int           onehot_bad = 0;
    logic [N-1:0] prev_en = '0;
    logic [15:0]  exp_frames = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++)
            if (layer_en[i] && !prev_en[i]) rise[i] = cyc;
        prev_en = layer_en;
        if (done) begin
            done_n++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if ($countones(layer_en) > 1) onehot_bad++;
    end

    // Runs one frame and checks it against the arithmetic timing model.
    task automatic run_frame(input string tag, input int l[N], output int dur);
        int t, s, base, e, k;
        t = 0;
        while (busy && t < 2000) begin @(negedge clk); t++; end
        lat   = l;
        base  = done_n;
        start = 1'b1;
        s     = cyc;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (done_n == base && t < 2000) begin @(negedge clk); t++; end
        chk({tag, " done_seen"}, 32'(done_n > base), 1);
        e = s + RC + 1;
        k = e;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s en%0d_rise", tag, i), rise[i], e);
            k = e + l[i];
            e = k + RC + 1;
        end
        chk({tag, " done_cycle"}, done_cyc, k + 2);
        chk({tag, " busy_at_done"}, done_busy, 0);
        exp_frames = exp_frames + 16'd1;
        chk({tag, " frame_cnt"}, frame_cnt, exp_frames);
        repeat (2) @(negedge clk);
        chk({tag, " one_done"}, done_n, base + 1);
        dur = done_cyc - s;
    endtask

    typedef struct {
        int l[N];
        int dur;
    } frame_vec_t;

    frame_vec_t tbl[4];

    initial begin
        int d, t;
        int l[N];
        int base;
        for (int i = 0; i < N; i++) lat[i] = 1;

        repeat (2) @(negedge clk);
        chk("rst layer_rst", layer_rst, 0);
        chk("rst layer_en", layer_en, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst cur_layer", cur_layer, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        chk("rst wdt_err", wdt_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Expected duration: start cycle to done = N*(RC+1) + 2 + sum(lat).
        tbl[0] = '{l: '{20, 20, 20, 20, 20}, dur: 117};
        tbl[1] = '{l: '{1, 1, 1, 1, 1},      dur: 22};
        tbl[2] = '{l: '{3, 7, 1, 12, 5},     dur: 45};
        tbl[3] = '{l: '{8, 2, 2, 2, 30},     dur: 61};
        for (int v = 0; v < 4; v++) begin
            run_frame($sformatf("tbl%0d", v), tbl[v].l, d);
            chk($sformatf("tbl%0d dur", v), d, tbl[v].dur);
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) l[i] = $urandom_range(1, 8);
            run_frame($sformatf("rnd%0d", r), l, d);
        end

        // Foreign fin[3] during layer 1, stale fin[1] during its reset window.
        l = '{4, 6, 3, 3, 3};
        fork
            run_frame("stale", l, d);
            begin
                t = 0;
                while (!layer_rst[1] && t < 500) begin @(negedge clk); t++; end
                chk("stale rst1_seen", layer_rst[1], 1);
                fin_x = 5'b01010;
                chk("stale cur_layer_rst", cur_layer, 1);
                t = 0;
                while (!layer_en[1] && t < 50) begin @(negedge clk); t++; end
                fin_x[1] = 1'b0;
                chk("stale cur_layer_en", cur_layer, 1);
                t = 0;
                while (layer_en[1] && t < 50) begin @(negedge clk); t++; end
                fin_x = '0;
            end
        join

        // Start pulsed while layer 2 is enabled must be ignored.
        l = '{3, 3, 6, 3, 3};
        fork
            run_frame("busy_start", l, d);
            begin
                t = 0;
                while (!layer_en[2] && t < 500) begin @(negedge clk); t++; end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        base = done_n;
        repeat (30) @(negedge clk);
        chk("busy_start no_second_frame", done_n, base);
        chk("busy_start idle", busy, 0);

        // Abort while layer 2 is enabled.
        lat = '{10, 10, 10, 10, 10};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!layer_en[2] && t < 500) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        base  = done_n;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort layer_en", layer_en, 0);
        chk("abort layer_rst", layer_rst, 5'b11111);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        @(negedge clk);
        chk("abort rst_pulse_end", layer_rst, 0);
        repeat (100) @(negedge clk);
        chk("abort no_done", done_n, base);
        chk("abort frame_cnt", frame_cnt, exp_frames);
        l = '{2, 4, 6, 4, 2};
        run_frame("after_abort", l, d);

        // Start and abort together in IDLE: start wins.
        lat   = '{2, 2, 2, 2, 2};
        base  = done_n;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort layer_rst", layer_rst, 5'b00001);
        chk("start_abort busy", busy, 1);
        t = 0;
        while (done_n == base && t < 500) begin @(negedge clk); t++; end
        exp_frames = exp_frames + 16'd1;
        chk("start_abort frame_cnt", frame_cnt, exp_frames);

`ifdef LAYER_SEQ_WDT_EN
        // Engine 0 never finishes: watchdog expires after WL enabled cycles.
        hang  = 5'b00001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!layer_en[0] && t < 50) begin @(negedge clk); t++; end
        t = 0;
        while (layer_en[0] && t < 1000) begin @(negedge clk); t++; end
        chk("wdt en_cycles", t, WL);
        chk("wdt err", wdt_err, 1);
        chk("wdt layer_rst", layer_rst, 5'b00001);
        chk("wdt busy", busy, 0);
        @(negedge clk);
        chk("wdt rst_pulse_end", layer_rst, 0);
        chk("wdt err_sticky", wdt_err, 1);
        chk("wdt frame_cnt", frame_cnt, exp_frames);
        hang = '0;
        l = '{2, 2, 2, 2, 2};
        fork
            run_frame("wdt_next", l, d);
            begin
                @(negedge clk);
                chk("wdt err_cleared", wdt_err, 0);
            end
        join
`else
        chk("wdt_err tied", wdt_err, 0);
`endif

        // Preload the counter near its wrap point instead of running 65535 frames.
        force dut.frame_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        exp_frames = 16'hFFFE;
        chk("wrap preload", frame_cnt, 16'hFFFE);
        l = '{1, 1, 1, 1, 1};
        run_frame("wrap_ffff", l, d);
        run_frame("wrap_zero", l, d);

        // Asynchronous reset mid-frame.
        lat   = '{3, 3, 3, 3, 3};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!layer_en[1] && t < 500) begin @(negedge clk); t++; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst layer_rst", layer_rst, 0);
        chk("arst layer_en", layer_en, 0);
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst cur_layer", cur_layer, 0);
        chk("arst frame_cnt", frame_cnt, 0);
        chk("arst wdt_err", wdt_err, 0);
        exp_frames = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        l = '{2, 5, 1, 3, 4};
        run_frame("post_arst", l, d);

        chk("onehot_en", onehot_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
